fc1_bias_reader: RTL and testbench
==================================

# fc1_bias_reader

Read-side initiator for the FC1 bias ROM. On `start`, the block fetches each FC1 output batch's packed bias vector from the ROM, applying the ROM's active-low chip enable and its one-cycle registered read latency. It adds that vector lane-wise to the matching accumulator batch, with saturation and optional ReLU, and streams the biased results downstream under valid/ready. It sits between the FC1 MAC array's accumulator output and the FC1 result writer.

## Interface
Parameters:
- `OUTPUT_BATCH_FC1`, 4: batches per frame.
- `OUTPUT_NUM_FC1`, 16: lanes per batch.
- `WD_BIAS`, 34: signed bias width per lane, equal to the ROM lane width.
- `WD_ACC`, 34: signed accumulator and output width per lane.
- `W_BATCH`, 2: width of the batch address.

Ports:
- `clk`, in, 1: single clock; all logic on posedge.
- `rstn`, in, 1: asynchronous active-low reset.
- `start`, in, 1: one-cycle pulse that begins a frame; sampled only in IDLE.
- `relu_en`, in, 1: when 1, negative results clamp to 0; sampled at `start`.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse after the last batch is accepted downstream.
- `rom_aa`, out, `W_BATCH`: ROM batch address.
- `rom_cena`, out, 1: ROM chip enable, active low.
- `rom_qa`, in, `WD_BIAS*OUTPUT_NUM_FC1`: ROM data, valid the cycle after `rom_cena`=0.
- `acc_valid`, in, 1: upstream accumulator batch valid.
- `acc_ready`, out, 1: upstream accept.
- `acc_data`, in, `WD_ACC*OUTPUT_NUM_FC1`: packed accumulator batch; lane 0 is in the MSBs.
- `out_valid`, out, 1: downstream valid.
- `out_ready`, in, 1: downstream accept.
- `out_data`, out, `WD_ACC*OUTPUT_NUM_FC1`: packed biased batch, same lane order as `acc_data`.
- `out_last`, out, 1: high with `out_valid` on the final batch of the frame.

## Operation
- The FSM has five states: IDLE, REQ, CAP, ADD, OUT. A batch counter `b` runs 0 to `OUTPUT_BATCH_FC1-1`.
- IDLE: `rom_cena`=1. `start` clears `b` to 0, latches `relu_en` and moves to REQ. `start` in any other state is ignored.
- REQ, one cycle: `rom_cena`=0 and `rom_aa`=`b`, then move to CAP.
- CAP, one cycle: `rom_cena`=1. Latch `rom_qa` into `bias_reg`, then move to ADD.
- ADD: `acc_ready`=1. On `acc_valid`&&`acc_ready`, register the per-lane result into `out_data`, set `out_valid`=1, set `out_last`=(`b`==`OUTPUT_BATCH_FC1-1`), and move to OUT.
- OUT: `out_valid`, `out_data` and `out_last` are held stable until `out_ready` is high.
  - On `out_valid`&&`out_ready` when `b` is the last batch: pulse `done`, clear `out_valid`, go to IDLE.
  - Otherwise: increment `b`, clear `out_valid`, go to REQ.
- Lane arithmetic:
  - sum = sext(acc) + sext(bias), computed at `WD_ACC+1` bits.
  - Saturate to [-2^(WD_ACC-1), 2^(WD_ACC-1)-1].
  - If the latched relu flag is set and the result is negative, output 0.
- `rom_aa` holds its last value whenever `rom_cena`=1.

## Timing
- Reset values: `busy`=0, `done`=0, `rom_cena`=1, `rom_aa`=0, `acc_ready`=0, `out_valid`=0, `out_data`=0, `out_last`=0, state IDLE, `b`=0.
- If `start` is sampled in cycle 0: REQ in cycle 1, CAP in cycle 2, `acc_ready`=1 from cycle 3.
- If `acc_valid` is already high, `out_valid` rises one cycle after the ADD handshake.
- Minimum 4 cycles per batch; a 4-batch frame with no stalls takes 16 cycles from `start` to the `done` edge.
- `acc_ready` is combinational from state only and never depends on `out_ready`. `acc_data` is not consumed outside ADD.
- Reset asserted mid-frame returns the block to IDLE immediately with all outputs at their reset values. Any partially delivered batch is dropped.

## Structure
- Shared package `fc1_pkg` holds the constants `OUTPUT_BATCH_FC1`, `OUTPUT_NUM_FC1`, `WD_BIAS`, `WD_ACC`, `W_BATCH` and the FSM state enum `fc1_brd_state_t`.
- One sub-module, `bias_sat_lane`: combinational single-lane add, saturate and ReLU, instantiated `OUTPUT_NUM_FC1` times in a generate loop.

## Test plan
- Batch 0, all acc lanes 0, `relu_en`=0: out lane 0 = -43163716 and lane 1 = 170595872. The ROM sees `rom_cena`=0 with `rom_aa`=0 in cycle 1.
- Full frame with acc lanes 0 and `out_ready`=1: batch 3 lane 0 = 582799168, `out_last`=1 only on batch 3, single `done` pulse, 16 cycles total.
- Saturation, batch 0 lane 1: acc=8589934591 (2^33-1) + 170595872 -> 8589934591. Lane 0: acc=-8589934592 + (-43163716) -> -8589934592.
- ReLU, `relu_en`=1, batch 0, acc 0: lane 0 -> 0 and lane 1 -> 170595872.
- Backpressure: `out_ready` held low for 5 cycles in OUT. `out_data`, `out_valid` and `out_last` stay stable, `acc_ready`=0, and no ROM request is issued.
- Reset pulse while in ADD of batch 2: all outputs go to reset values. A subsequent `start` fetches `rom_aa`=0 first.

Source files
------------

// File: rtl/fc1_pkg.sv
// Shared constants and FSM state type for the FC1 bias read path.
package fc1_pkg;
    localparam int OUTPUT_BATCH_FC1 = 4;
    localparam int OUTPUT_NUM_FC1   = 16;
    localparam int WD_BIAS          = 34;
    localparam int WD_ACC           = 34;
    localparam int W_BATCH          = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_CAP,
        ST_ADD,
        ST_OUT
    } fc1_brd_state_t;
endpackage

// File: rtl/bias_sat_lane.sv
// One lane of the bias add: widen by one bit, add, clamp to the accumulator range, optional ReLU.
module bias_sat_lane #(
    parameter int WD_ACC  = 34,
    parameter int WD_BIAS = 34
) (
    input  logic signed [WD_ACC-1:0]  acc_i,
    input  logic signed [WD_BIAS-1:0] bias_i,
    input  logic                      relu_i,
    output logic signed [WD_ACC-1:0]  res_o
);
    localparam logic [WD_ACC-1:0] SAT_MAX = {1'b0, {(WD_ACC-1){1'b1}}};
    localparam logic [WD_ACC-1:0] SAT_MIN = {1'b1, {(WD_ACC-1){1'b0}}};

    logic [WD_ACC:0] sum;

    always_comb begin
        sum = {acc_i[WD_ACC-1], acc_i}
            + {{(WD_ACC+1-WD_BIAS){bias_i[WD_BIAS-1]}}, bias_i};
        // The two top bits disagree only when the true sum left the representable range.
        if (sum[WD_ACC] != sum[WD_ACC-1]) begin
            res_o = sum[WD_ACC] ? SAT_MIN : SAT_MAX;
        end else begin
            res_o = sum[WD_ACC-1:0];
        end
        if (relu_i && res_o[WD_ACC-1]) begin
            res_o = '0;
        end
    end
endmodule

// File: rtl/fc1_bias_reader.sv
// Fetches each FC1 batch's bias vector from the ROM, adds it to the accumulator batch and streams it out.
module fc1_bias_reader
    import fc1_pkg::*;
#(
    parameter int P_BATCH = OUTPUT_BATCH_FC1,
    parameter int P_NUM   = OUTPUT_NUM_FC1,
    parameter int P_WB    = WD_BIAS,
    parameter int P_WA    = WD_ACC,
    parameter int P_WBAT  = W_BATCH
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic                    relu_en,
    output logic                    busy,
    output logic                    done,
    output logic [P_WBAT-1:0]       rom_aa,
    output logic                    rom_cena,
    input  logic [P_WB*P_NUM-1:0]   rom_qa,
    input  logic                    acc_valid,
    output logic                    acc_ready,
    input  logic [P_WA*P_NUM-1:0]   acc_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [P_WA*P_NUM-1:0]   out_data,
    output logic                    out_last
);
    localparam logic [P_WBAT-1:0] LAST_B = P_WBAT'(P_BATCH - 1);

    fc1_brd_state_t          state_q, state_d;
    logic [P_WBAT-1:0]       b_q, b_d;
    logic [P_WBAT-1:0]       aa_q, aa_d;
    logic                    relu_q, relu_d;
    logic [P_WB*P_NUM-1:0]   bias_q, bias_d;
    logic [P_WA*P_NUM-1:0]   data_q, data_d;
    logic                    vld_q, vld_d;
    logic                    last_q, last_d;
    logic                    done_q, done_d;
    logic [P_WA*P_NUM-1:0]   sum_vec;

    // Lane 0 occupies the MSBs of every packed vector.
    for (genvar gi = 0; gi < P_NUM; gi++) begin : g_lane
        bias_sat_lane #(.WD_ACC(P_WA), .WD_BIAS(P_WB)) u_lane (
            .acc_i  (acc_data[(P_NUM-1-gi)*P_WA +: P_WA]),
            .bias_i (bias_q[(P_NUM-1-gi)*P_WB +: P_WB]),
            .relu_i (relu_q),
            .res_o  (sum_vec[(P_NUM-1-gi)*P_WA +: P_WA])
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            b_q     <= '0;
            aa_q    <= '0;
            relu_q  <= 1'b0;
            bias_q  <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            aa_q    <= aa_d;
            relu_q  <= relu_d;
            bias_q  <= bias_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        b_d       = b_q;
        aa_d      = aa_q;
        relu_d    = relu_q;
        bias_d    = bias_q;
        data_d    = data_q;
        vld_d     = vld_q;
        last_d    = last_q;
        done_d    = 1'b0;
        acc_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    b_d     = '0;
                    aa_d    = '0;
                    relu_d  = relu_en;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: state_d = ST_CAP;
            ST_CAP: begin
                bias_d  = rom_qa;
                state_d = ST_ADD;
            end
            ST_ADD: begin
                acc_ready = 1'b1;
                if (acc_valid) begin
                    data_d  = sum_vec;
                    vld_d   = 1'b1;
                    last_d  = (b_q == LAST_B);
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    vld_d  = 1'b0;
                    last_d = 1'b0;
                    if (b_q == LAST_B) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        // The ROM address only moves when the next request is set up.
                        b_d     = b_q + 1'b1;
                        aa_d    = b_q + 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign rom_cena  = (state_q != ST_REQ);
    assign rom_aa    = aa_q;
    assign out_valid = vld_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign done      = done_q;
endmodule

// File: tb/tb_fc1_bias_reader.sv
// Directed bench for fc1_bias_reader with a registered-read ROM model.
module tb_fc1_bias_reader;
    localparam int N = 16;
    localparam int W = 34;

    logic           clk;
    logic           rstn;
    logic           start;
    logic           relu_en;
    logic           busy;
    logic           done;
    logic [1:0]     rom_aa;
    logic           rom_cena;
    logic [N*W-1:0] rom_qa;
    logic           acc_valid;
    logic           acc_ready;
    logic [N*W-1:0] acc_data;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] out_data;
    logic           out_last;

    int nvec = 0;
    int nerr = 0;

    fc1_bias_reader dut (
        .clk(clk), .rstn(rstn), .start(start), .relu_en(relu_en),
        .busy(busy), .done(done), .rom_aa(rom_aa), .rom_cena(rom_cena),
        .rom_qa(rom_qa), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .acc_data(acc_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [W-1:0] bias_val(input int b, input int l);
        if (b == 0 && l == 0) return -43163716;
        if (b == 0 && l == 1) return 170595872;
        if (b == 3 && l == 0) return 582799168;
        return (b * 16 + l) * 1000003 - 20000000;
    endfunction

    function automatic logic [N*W-1:0] rom_word(input int b);
        logic [N*W-1:0] w;
        w = '0;
        for (int l = 0; l < N; l++) w[(N-1-l)*W +: W] = bias_val(b, l);
        return w;
    endfunction

    function automatic logic signed [W-1:0] lane_of(input logic [N*W-1:0] d, input int i);
        return d[(N-1-i)*W +: W];
    endfunction

    always @(posedge clk) begin
        if (!rom_cena) rom_qa <= rom_word(int'(rom_aa));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    logic [N*W-1:0] exp_vec;
    int             nout;
    int             first_done;
    int             ndone;
    logic signed [W-1:0] b3l0;

    initial begin
        rstn = 1'b0; start = 1'b0; relu_en = 1'b0;
        acc_valid = 1'b0; acc_data = '0; out_ready = 1'b0;
        rom_qa = '0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cena", rom_cena, 1);
        chk("rst_aa", rom_aa, 0);
        chk("rst_accrdy", acc_ready, 0);
        chk("rst_oval", out_valid, 0);
        chk("rst_olast", out_last, 0);
        nvec++;
        assert (out_data === '0) else begin
            nerr++;
            $error("FAIL rst_odata: observed %h, expected 0", out_data);
        end
        rstn = 1'b1;
        tick();

        // Full frame, acc = 0, no stalls.
        acc_valid = 1'b1; out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        nout = 0; first_done = 0; ndone = 0; b3l0 = '0;
        for (int cyc = 1; cyc <= 22; cyc++) begin
            if (cyc == 1) begin
                chk("f_c1_cena", rom_cena, 0);
                chk("f_c1_aa", rom_aa, 0);
                chk("f_c1_busy", busy, 1);
            end
            if (cyc == 2) chk("f_c2_accrdy", acc_ready, 0);
            if (cyc == 3) chk("f_c3_accrdy", acc_ready, 1);
            if (cyc == 4) begin
                chk("f_b0_oval", out_valid, 1);
                chk("f_b0_l0", lane_of(out_data, 0), -43163716);
                chk("f_b0_l1", lane_of(out_data, 1), 170595872);
            end
            if (out_valid) begin
                chk("f_last", out_last, (nout == 3) ? 1 : 0);
                if (nout == 3) b3l0 = lane_of(out_data, 0);
                nout++;
            end
            if (done) begin
                ndone++;
                if (first_done == 0) first_done = cyc;
            end
            tick();
        end
        chk("f_b3_l0", b3l0, 582799168);
        chk("f_nout", nout, 4);
        chk("f_ndone", ndone, 1);
        chk("f_cycles", first_done - 1, 16);
        chk("f_idle", busy, 0);

        // Saturation on batch 0, then backpressure.
        acc_data = '0;
        acc_data[(N-1)*W +: W] = {1'b1, {(W-1){1'b0}}};
        acc_data[(N-2)*W +: W] = {1'b0, {(W-1){1'b1}}};
        out_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("s_l0", lane_of(out_data, 0), -64'sd8589934592);
        chk("s_l1", lane_of(out_data, 1), 64'sd8589934591);
        chk("s_l2", lane_of(out_data, 2), bias_val(0, 2));
        exp_vec = rom_word(0);
        exp_vec[(N-1)*W +: W] = {1'b1, {(W-1){1'b0}}};
        exp_vec[(N-2)*W +: W] = {1'b0, {(W-1){1'b1}}};
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_oval", out_valid, 1);
            chk("bp_olast", out_last, 0);
            chk("bp_accrdy", acc_ready, 0);
            chk("bp_cena", rom_cena, 1);
            nvec++;
            assert (out_data === exp_vec) else begin
                nerr++;
                $error("FAIL bp_odata: observed %h, expected %h", out_data, exp_vec);
            end
        end
        out_ready = 1'b1; acc_data = '0;
        tick();
        chk("bp_req_cena", rom_cena, 0);
        chk("bp_req_aa", rom_aa, 1);
        tick(); tick(); tick(); tick(); tick();
        acc_valid = 1'b0;
        tick();
        chk("r_in_add", acc_ready, 1);
        chk("r_in_add_aa", rom_aa, 2);

        // Asynchronous reset in ADD of batch 2.
        #2 rstn = 1'b0;
        #1;
        chk("r_busy", busy, 0);
        chk("r_accrdy", acc_ready, 0);
        chk("r_oval", out_valid, 0);
        chk("r_aa", rom_aa, 0);
        chk("r_cena", rom_cena, 1);
        tick();
        rstn = 1'b1;
        tick();

        // ReLU frame; relu_en is only looked at on start.
        acc_data = '0; acc_valid = 1'b1; out_ready = 1'b1;
        relu_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; relu_en = 1'b0;
        chk("rl_cena", rom_cena, 0);
        chk("rl_aa", rom_aa, 0);
        tick(); tick(); tick();
        chk("rl_oval", out_valid, 1);
        chk("rl_l0", lane_of(out_data, 0), 0);
        chk("rl_l1", lane_of(out_data, 1), 170595872);
        chk("rl_l2", lane_of(out_data, 2), 0);
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) ndone++;
            tick();
        end
        chk("rl_ndone", ndone, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
